// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: MIPS load/store op codes,
// FSM state encoding, default memory depth and the byte/half lane geometry.
package mem_pkg;

  localparam int MEM_WORDS_DEF = 128;
  localparam int BYTE_W        = 8;
  localparam int HALF_W        = 16;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction for loads and lane merge for sub-word stores.
// Byte offset 0 is bits[31:24]; half offset 0 is bits[31:16].
module mem_lane_align
  import mem_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_sh  = {~off, 3'b000};
    half_sh  = {~off[1], 4'b0000};
    byte_v   = 8'(word >> byte_sh);
    half_v   = 16'(word >> half_sh);
    load_val = word;
    merged   = word;
    case (op)
      OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_val = {24'd0, byte_v};
      OP_LH:   load_val = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_val = {16'd0, half_v};
      default: load_val = word;
    endcase
    case (op)
      OP_SB:   merged = (word & ~(BYTE_MASK << byte_sh)) | ((wdata & BYTE_MASK) << byte_sh);
      OP_SH:   merged = (word & ~(HALF_MASK << half_sh)) | ((wdata & HALF_MASK) << half_sh);
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Converts byte-addressed MIPS loads/stores into word accesses on a
// word-addressed data memory; sub-word stores use a two-cycle read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_exc,
  output logic              range_exc,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                load_valid_q, load_valid_d;
  logic                misalign_q, misalign_d;
  logic                range_q, range_d;
  logic [ADDR_W-1:0]   exc_addr_q, exc_addr_d;
  logic [31:0]         merged_q, merged_d;
  logic [ADDR_W-3:0]   idx_q, idx_d;

  op_e                 op;
  logic [ADDR_W-3:0]   req_idx;
  logic                is_load, misaligned, out_of_range;
  logic [31:0]         lane_load, lane_merged;

  assign op      = op_e'(req_op);
  assign req_idx = req_addr[ADDR_W-1:2];
  assign is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
                   (op == OP_LHU) || (op == OP_LW);

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      OP_LW, OP_SW:         misaligned = |req_addr[1:0];
      default:              misaligned = 1'b0;
    endcase
    out_of_range = req_idx >= (ADDR_W-2)'(MEM_WORDS);
  end

  mem_lane_align u_align (
    .op       (op),
    .off      (req_addr[1:0]),
    .word     (mem_rdata),
    .wdata    (req_wdata),
    .load_val (lane_load),
    .merged   (lane_merged)
  );

  always_comb begin
    state_d      = state_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    range_d      = 1'b0;
    exc_addr_d   = exc_addr_q;
    merged_d     = merged_q;
    idx_d        = idx_q;
    stall        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = 32'd0;
    mem_addr     = {2'b00, req_idx};
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Misalignment wins over range; a faulting access never touches memory.
          if (misaligned) begin
            misalign_d = 1'b1;
            exc_addr_d = req_addr;
          end else if (out_of_range) begin
            range_d    = 1'b1;
            exc_addr_d = req_addr;
          end else if (is_load) begin
            mem_read     = 1'b1;
            load_data_d  = lane_load;
            load_valid_d = 1'b1;
          end else if (op == OP_SW) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            merged_d = lane_merged;
            idx_d    = req_idx;
            state_d  = S_RMW_WR;
          end
        end
      end
      S_RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = merged_q;
        mem_addr  = {2'b00, idx_q};
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset in the write cycle must leave memory untouched.
    if (!rst_n) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      range_q      <= 1'b0;
      exc_addr_q   <= '0;
      merged_q     <= 32'd0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      range_q      <= range_d;
      exc_addr_q   <= exc_addr_d;
      merged_q     <= merged_d;
      idx_q        <= idx_d;
    end
  end

  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign misalign_exc = misalign_q;
  assign range_exc    = range_q;
  assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 128-word behavioural data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_exc;
  logic        range_exc;
  logic [31:0] exc_addr;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                         LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_exc (misalign_exc),
    .range_exc    (range_exc),
    .exc_addr     (exc_addr),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Combinational read with write-data forwarding.
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_addr < 32'd128) begin
      if (mem_write) mem_rdata = mem_wdata;
      else           mem_rdata = mem[mem_addr[6:0]];
    end
  end

  always @(posedge clk)
    if (mem_write && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] exp);
    issue(op, addr, 32'd0);
    chk({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({tag, "_vld"}, {31'd0, load_valid}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
  endtask

  task automatic do_rmw(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_word, input bit rst_in_wr);
    issue(op, addr, wd);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    #1;
    if (rst_in_wr) rst_n = 1'b0;
    #1;
    chk({tag, "_wr_stall"}, {31'd0, stall}, 32'd0);
    if (rst_in_wr) begin
      chk({tag, "_wr_supp"}, {31'd0, mem_write}, 32'd0);
    end else begin
      chk({tag, "_wr"}, {31'd0, mem_write}, 32'd1);
      chk({tag, "_wdata"}, mem_wdata, exp_word);
      chk({tag, "_waddr"}, mem_addr, {2'b00, addr[31:2]});
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_idle_wr"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem"}, mem[addr[8:2]], exp_word);
  endtask

  task automatic do_err(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input bit exp_mis, input bit exp_rng);
    issue(op, addr, 32'hDEAD_BEEF);
    chk({tag, "_ctl"}, {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({tag, "_mis"}, {31'd0, misalign_exc}, {31'd0, exp_mis});
    chk({tag, "_rng"}, {31'd0, range_exc}, {31'd0, exp_rng});
    chk({tag, "_eaddr"}, exc_addr, addr);
    chk({tag, "_lvld"}, {31'd0, load_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, misalign_exc, range_exc}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[0] = 32'd0; mem[1] = 32'd2; mem[2] = 32'd5; mem[3] = 32'd4;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {26'd0, stall, load_valid, misalign_exc, range_exc, mem_read, mem_write}, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_eaddr", exc_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_load("lw08", LW, 32'h08, 32'h0000_0005);
    do_load("lb0f", LB, 32'h0F, 32'h0000_0004);
    do_load("lh0a", LH, 32'h0A, 32'h0000_0005);
    do_load("lhu08", LHU, 32'h08, 32'h0000_0000);

    do_rmw("sb05", SB, 32'h05, 32'h0000_00AB, 32'h00AB_0002, 1'b0);
    do_load("lw04", LW, 32'h04, 32'h00AB_0002);

    do_rmw("sb0c", SB, 32'h0C, 32'h0000_0080, 32'h8000_0004, 1'b0);
    do_load("lb0c", LB, 32'h0C, 32'hFFFF_FF80);
    do_load("lbu0c", LBU, 32'h0C, 32'h0000_0080);
    do_rmw("sh0e", SH, 32'h0E, 32'h0000_1234, 32'h8000_1234, 1'b0);
    do_load("lw0c", LW, 32'h0C, 32'h8000_1234);
    do_load("lhu0c", LHU, 32'h0C, 32'h0000_8000);
    do_load("lh0c", LH, 32'h0C, 32'hFFFF_8000);

    issue(SW, 32'h10, 32'hCAFE_F00D);
    chk("sw10_wr", {30'd0, mem_read, mem_write}, 32'd1);
    chk("sw10_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("sw10_stall", {31'd0, stall}, 32'd0);
    do_load("lb10", LB, 32'h10, 32'hFFFF_FFCA);

    do_err("lw06", LW, 32'h06, 1'b1, 1'b0);
    do_err("lw200", LW, 32'h200, 1'b0, 1'b1);
    do_err("sh201", SH, 32'h201, 1'b1, 1'b0);
    do_err("sb1ff", SB, 32'h3FF, 1'b0, 1'b1);

    do_rmw("sb01rst", SB, 32'h01, 32'h0000_0077, 32'h0000_0000, 1'b1);
    do_load("lw00", LW, 32'h00, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX stage and the word-addressed data memory (128 x 32-bit, combinational read, write on posedge, write data forwarded on read port).
- Converts byte-addressed MIPS loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses.
- Sub-word stores use a two-cycle read-modify-write. Sub-word loads are extracted and sign/zero-extended.
- Flags misaligned and out-of-range accesses.

Parameters:
MEM_WORDS, 128, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range
ADDR_W, 32, byte address width from EX

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  EX presents a memory operation this cycle
req_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
req_addr  in  32  byte address
req_wdata  in  32  store data; byte/half taken from LSBs
stall  out  1  high while an RMW is in progress; upstream holds req_* stable
load_data  out  32  extended load result, registered
load_valid  out  1  one-cycle pulse with load_data
misalign_exc  out  1  one-cycle pulse, misaligned access
range_exc  out  1  one-cycle pulse, word index >= MEM_WORDS
exc_addr  out  32  faulting byte address, registered
mem_addr  out  32  word index = req_addr[31:2]
mem_read  out  1  memory read control
mem_write  out  1  memory write control
mem_wdata  out  32  word written to memory
mem_rdata  in  32  combinational memory read data

Behaviour:
- One clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: state=IDLE. stall, load_valid, misalign_exc, range_exc, mem_read and mem_write are 0. load_data, exc_addr and mem_wdata are 0.
- Byte order is big-endian.
  - Byte offset 0 = bits[31:24], offset 3 = bits[7:0].
  - Half offset 0 = bits[31:16], offset 2 = bits[15:0].
- Alignment rules:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Bytes are always aligned.
- Error checks and priority (checked in IDLE when req_valid=1):
  - Misalign has priority over range.
  - On any error: no mem_read/mem_write is issued. The matching exc pulses next cycle. exc_addr <= req_addr. load_valid stays 0.
- FSM states: IDLE, RMW_WR.
- IDLE, valid load:
  - mem_read=1 combinationally.
  - At posedge, load_data <= extracted and extended mem_rdata. load_valid=1 for one cycle after.
  - Latency 1 cycle, no stall.
  - LB/LH sign-extend. LBU/LHU zero-extend.
- IDLE, valid SW:
  - mem_write=1 and mem_wdata=req_wdata in the same cycle.
  - Single cycle, no stall.
- IDLE, valid SB/SH:
  - mem_read=1. stall=1 combinationally.
  - At posedge, latch merged word: mem_rdata with the selected lane replaced by req_wdata[7:0] or [15:0]. Latch the word index.
  - Go to RMW_WR.
- RMW_WR:
  - mem_write=1, mem_wdata=merged word, mem_addr=latched index, stall=0.
  - Return to IDLE. A new request is not accepted in this cycle.
  - EX advances at the end of this cycle.
- req_valid=0 in IDLE: all memory controls are 0 and outputs hold, except the pulses, which clear.
- mem_read and mem_write are never both 1.
- Reset asserted in RMW_WR: the write is suppressed in that cycle and state returns to IDLE. Memory is unchanged.
- Back-to-back:
  - A load following SW in the next cycle sees the new data, because memory has written by then.
  - A load immediately after an RMW is taken in the cycle after RMW_WR.
- Address bits [31:2] beyond the range check are passed unchanged on mem_addr.

Decomposition:
- Shared package `mem_pkg`: op encodings (OP_LB..OP_SW), FSM state encoding, MEM_WORDS default, and the lane-select constants.
- One natural sub-module: `mem_lane_align`, combinational.
  - Inputs: op, byte offset, word.
  - Outputs: extended load value and merged store word.
  - Used by both the load and RMW paths.

Test Plan:
- Initial memory words 0..3 = 0,2,5,4. LW addr 0x08 -> load_valid one cycle later, load_data=0x00000005, stall never asserted.
- LB addr 0x0F -> 0x00000004. LH addr 0x0A -> 0x00000005. LHU addr 0x08 -> 0x00000000.
- SB 0x000000AB to addr 0x05:
  - stall=1 for one cycle, then mem_write of 0x00AB0002 to index 1.
  - A following LW 0x04 -> 0x00AB0002.
- SB 0x80 to addr 0x0C, then LB 0x0C -> 0xFFFFFF80 and LBU 0x0C -> 0x00000080.
  - SH 0x1234 to addr 0x0E -> word3 = 0x80001234.
- LW addr 0x06 -> misalign_exc pulse, exc_addr=0x00000006, no mem_read/mem_write, load_valid=0.
  - LW addr 0x200 (index 128) -> range_exc, exc_addr=0x00000200.
- SB to addr 0x01 with rst_n driven low in the RMW_WR cycle -> no write, state IDLE, word0 still 0x00000000.
